// File: rtl/div_seq_if.sv
// Request/response bundle between the EX stage and the multi-cycle divider.
// The EX side drives the operands and start/annul; the divider returns result, ready and stall.
interface div_seq_if #(
  parameter int DATA_W = 32
);
  logic                  start_i;
  logic                  annul_i;
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
  logic                  stall_o;

  modport master (
    output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, stall_o
  );

  modport slave (
    input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    output result_o, ready_o, stall_o
  );
endinterface

// File: rtl/div_seq.sv
// Restoring radix-2 divider for DIV/DIVU, one quotient bit per clock.
// Result is {remainder, quotient} for the HI:LO write path.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_FREE     | idle, waiting for start_i without annul_i
// S_DIVZERO  | divisor was zero; result is forced to zero
// S_ON       | iterating, cnt counts completed quotient bits
// S_END      | result valid, held until start_i drops
module div_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input logic      clk,
  input logic      rst,
  div_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_FREE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DATA_W);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*DATA_W:0]     dividend_q, dividend_d;
  logic [DATA_W-1:0]     divisor_q, divisor_d;
  logic                  sgn_q, sgn_d;
  logic                  neg1_q, neg1_d;
  logic                  neg2_q, neg2_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;

  logic [DATA_W:0]       tmp;
  logic [DATA_W-1:0]     quo;
  logic [DATA_W-1:0]     rem;
  logic [DATA_W-1:0]     op1_abs;
  logic [DATA_W-1:0]     op2_abs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_FREE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      sgn_q      <= 1'b0;
      neg1_q     <= 1'b0;
      neg2_q     <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      sgn_q      <= sgn_d;
      neg1_q     <= neg1_d;
      neg2_q     <= neg2_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    sgn_d      = sgn_q;
    neg1_d     = neg1_q;
    neg2_d     = neg2_q;
    result_d   = result_q;
    ready_d    = ready_q;

    // Trial subtraction of the divisor from the current partial remainder.
    tmp = {1'b0, dividend_q[2*DATA_W-1:DATA_W]} - {1'b0, divisor_q};

    quo = dividend_q[DATA_W-1:0];
    rem = dividend_q[2*DATA_W:DATA_W+1];
    if (sgn_q && (neg1_q ^ neg2_q)) quo = -quo;
    if (sgn_q && neg1_q)            rem = -rem;

    op1_abs = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i : bus.opdata1_i;
    op2_abs = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i : bus.opdata2_i;

    unique case (state_q)
      S_FREE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_d = S_DIVZERO;
          end else begin
            state_d    = S_ON;
            cnt_d      = '0;
            dividend_d = {DATA_W'(0), op1_abs, 1'b0};
            divisor_d  = op2_abs;
            sgn_d      = bus.signed_div_i;
            neg1_d     = bus.opdata1_i[DATA_W-1];
            neg2_d     = bus.opdata2_i[DATA_W-1];
          end
        end
      end

      S_DIVZERO: begin
        state_d    = S_END;
        dividend_d = '0;
        result_d   = '0;
      end

      S_ON: begin
        if (bus.annul_i) begin
          state_d  = S_FREE;
          cnt_d    = '0;
          ready_d  = 1'b0;
          result_d = '0;
        end else if (cnt_q != CNT_DONE) begin
          if (tmp[DATA_W]) begin
            dividend_d = {dividend_q[2*DATA_W-1:0], 1'b0};
          end else begin
            dividend_d = {tmp[DATA_W-1:0], dividend_q[DATA_W-1:0], 1'b1};
          end
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          result_d = {rem, quo};
          ready_d  = 1'b1;
          cnt_d    = '0;
          state_d  = S_END;
        end
      end

      S_END: begin
        // A zero-divisor result only becomes ready here, one edge after DIVZERO.
        if (bus.start_i) begin
          ready_d = 1'b1;
        end else begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end

      default: begin
        state_d = S_FREE;
      end
    endcase
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
  assign bus.stall_o  = bus.start_i & ~ready_q & ~bus.annul_i;

endmodule
